// File: rtl/parking_pkg.sv
// Shared types and constants for the parking occupancy block: occupancy width,
// default lot size, gate FSM states and the per-cycle occupancy decision.
package parking_pkg;

    localparam int OCC_W             = 4;
    localparam int DEFAULT_MAX_SLOTS = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2
    } gate_state_e;

    typedef enum logic [1:0] {
        OCC_HOLD   = 2'd0,
        OCC_INC    = 2'd1,
        OCC_DEC    = 2'd2,
        OCC_REJECT = 2'd3
    } occ_action_e;

    // Simultaneous enter and exit cancel out, so only a lone event can be
    // refused; INC/DEC are only issued when they cannot leave 0..MAX.
    function automatic occ_action_e occ_action(
        input logic enter_evt,
        input logic exit_evt,
        input logic at_max,
        input logic at_zero
    );
        occ_action_e act;
        act = OCC_HOLD;
        if (enter_evt && !exit_evt) begin
            act = at_max ? OCC_REJECT : OCC_INC;
        end else if (exit_evt && !enter_evt) begin
            act = at_zero ? OCC_REJECT : OCC_DEC;
        end
        return act;
    endfunction

endpackage

// File: rtl/parking_occupancy_fsm_if.sv
// Sensor inputs and occupancy/gate outputs of the parking occupancy block.
// The master side drives the sensors; the slave side is the block itself.
interface parking_occupancy_fsm_if;
    import parking_pkg::*;

    logic             enter_sensor;
    logic             exit_sensor;
    logic [OCC_W-1:0] fsm_state;
    logic             full;
    logic             empty;
    logic             gate_open;
    logic             gate_dir;
    logic             reject;

    modport master (
        output enter_sensor, exit_sensor,
        input  fsm_state, full, empty, gate_open, gate_dir, reject
    );

    modport slave (
        input  enter_sensor, exit_sensor,
        output fsm_state, full, empty, gate_open, gate_dir, reject
    );

endinterface

// File: rtl/sensor_edge_detect.sv
// Rising-edge detector for one car sensor, with an optional debounce filter
// enabled by the SENSOR_DEBOUNCE_EN macro.
module sensor_edge_detect
`ifdef SENSOR_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    logic armed;
    logic prev;
    logic level;

`ifdef SENSOR_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          filt;
    logic [CW-1:0] diff_cnt;

    // diff_cnt counts consecutive raw samples that disagree with the filtered level.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt     <= 1'b0;
            diff_cnt <= '0;
        end else if (!armed) begin
            filt     <= raw;
            diff_cnt <= '0;
        end else if (raw == filt) begin
            diff_cnt <= '0;
        end else if (diff_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            filt     <= raw;
            diff_cnt <= '0;
        end else begin
            diff_cnt <= diff_cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = raw;
`endif

    // The first cycle after reset only captures the current level, so a sensor
    // held high through reset must fall and rise again before it counts.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
            prev  <= 1'b0;
        end else begin
            armed <= 1'b1;
            prev  <= armed ? level : raw;
        end
    end

    assign rise = armed && level && !prev;

endmodule

// File: rtl/parking_occupancy_fsm.sv
// Parking lot occupancy counter (0..MAX_SLOTS) with a direction-aware gate FSM.
// Define SENSOR_DEBOUNCE_EN to debounce both sensors before edge detection.
module parking_occupancy_fsm
    import parking_pkg::*;
#(
    parameter int MAX_SLOTS   = DEFAULT_MAX_SLOTS,
    parameter int GATE_CYCLES = 8
`ifdef SENSOR_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    parking_occupancy_fsm_if.slave bus
);

    localparam int               TW         = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0]    TIMER_LOAD = TW'(GATE_CYCLES - 1);
    localparam logic [OCC_W-1:0] MAX_COUNT  = OCC_W'(MAX_SLOTS);

    logic enter_evt;
    logic exit_evt;

`ifdef SENSOR_DEBOUNCE_EN
    sensor_edge_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_edge (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.enter_sensor),
        .rise  (enter_evt)
    );

    sensor_edge_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_edge (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.exit_sensor),
        .rise  (exit_evt)
    );
`else
    sensor_edge_detect u_enter_edge (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.enter_sensor),
        .rise  (enter_evt)
    );

    sensor_edge_detect u_exit_edge (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.exit_sensor),
        .rise  (exit_evt)
    );
`endif

    logic [OCC_W-1:0] count_q, count_d;
    logic             full_q;
    logic             empty_q;
    logic             reject_q, reject_d;
    gate_state_e      gate_q, gate_d;
    logic [TW-1:0]    timer_q, timer_d;

    occ_action_e action;
    logic        accept_in;
    logic        accept_out;

    assign action = occ_action(enter_evt, exit_evt, full_q, empty_q);

    // A simultaneous enter/exit is accepted as an entry for gate purposes.
    assign accept_in  = enter_evt && (action != OCC_REJECT);
    assign accept_out = exit_evt && !enter_evt && (action != OCC_REJECT);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch can be inferred.
        count_d  = count_q;
        reject_d = 1'b0;
        gate_d   = gate_q;
        timer_d  = timer_q;

        case (action)
            OCC_INC:    count_d  = count_q + 1'b1;
            OCC_DEC:    count_d  = count_q - 1'b1;
            OCC_REJECT: reject_d = 1'b1;
            default:    ;
        endcase

        if (accept_in) begin
            gate_d  = OPEN_IN;
            timer_d = TIMER_LOAD;
        end else if (accept_out) begin
            gate_d  = OPEN_OUT;
            timer_d = TIMER_LOAD;
        end else if (gate_q != IDLE) begin
            if (timer_q == '0) begin
                gate_d = IDLE;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    // full/empty are derived from the next count so they never lag fsm_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            reject_q <= 1'b0;
            gate_q   <= IDLE;
            timer_q  <= '0;
        end else begin
            count_q  <= count_d;
            full_q   <= (count_d == MAX_COUNT);
            empty_q  <= (count_d == '0);
            reject_q <= reject_d;
            gate_q   <= gate_d;
            timer_q  <= timer_d;
        end
    end

    assign bus.fsm_state = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.reject    = reject_q;
    assign bus.gate_open = (gate_q != IDLE);
    assign bus.gate_dir  = (gate_q == OPEN_IN);

endmodule

// File: tb/tb_parking_occupancy_fsm.sv
// Scoreboard bench for parking_occupancy_fsm: directed scenarios plus random
// sensor traffic, checked every cycle against a behavioural lot model.
module tb_parking_occupancy_fsm;
    import parking_pkg::*;

    localparam int MAX_SLOTS   = 15;
    localparam int GATE_CYCLES = 8;
`ifdef SENSOR_DEBOUNCE_EN
    localparam int DEB = 4;
    localparam int PW  = 6;
`else
    localparam int PW  = 3;
`endif

    typedef struct packed {
        logic [3:0] state;
        logic       full;
        logic       empty;
        logic       open;
        logic       dir;
        logic       reject;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parking_occupancy_fsm_if bus ();

    parking_occupancy_fsm #(
        .MAX_SLOTS   (MAX_SLOTS),
        .GATE_CYCLES (GATE_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";
    obs_t  exp_q[$];

    // Behavioural lot model: a car count, the number of gate-open cycles still
    // owed, and which way the gate was last opened.
    int m_count     = 0;
    int m_gate_left = 0;
    bit m_dir_in    = 0;
    bit m_fresh     = 1;
    bit m_prev_e    = 0;
    bit m_prev_x    = 0;
`ifdef SENSOR_DEBOUNCE_EN
    bit m_filt_e = 0;
    bit m_filt_x = 0;
    bit hist_e[$];
    bit hist_x[$];

    function automatic bit settled_to(input bit h[$], input bit v);
        if (h.size() < DEB) return 1'b0;
        for (int i = h.size() - DEB; i < h.size(); i++) begin
            if (h[i] != v) return 1'b0;
        end
        return 1'b1;
    endfunction
`endif

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got state=%0d full=%b empty=%b open=%b dir=%b reject=%b, expected state=%0d full=%b empty=%b open=%b dir=%b reject=%b",
                     name, $time, act.state, act.full, act.empty, act.open, act.dir, act.reject,
                     exp.state, exp.full, exp.empty, exp.open, exp.dir, exp.reject);
        end
    endtask

    task automatic model_step(input bit r, input bit e_raw, input bit x_raw);
        bit   le, lx, ev_e, ev_x, rej, opened, open_in;
        obs_t o;
        ev_e = 0; ev_x = 0; rej = 0; opened = 0; open_in = 0;
        if (r) begin
            m_count = 0; m_gate_left = 0; m_dir_in = 0;
            m_fresh = 1; m_prev_e = 0; m_prev_x = 0;
`ifdef SENSOR_DEBOUNCE_EN
            m_filt_e = 0; m_filt_x = 0;
            hist_e.delete(); hist_x.delete();
`endif
        end else begin
            if (m_fresh) begin
                m_fresh = 0; m_prev_e = e_raw; m_prev_x = x_raw;
`ifdef SENSOR_DEBOUNCE_EN
                m_filt_e = e_raw; m_filt_x = x_raw;
                hist_e.push_back(e_raw); hist_x.push_back(x_raw);
`endif
            end else begin
`ifdef SENSOR_DEBOUNCE_EN
                le = m_filt_e; lx = m_filt_x;
                hist_e.push_back(e_raw); hist_x.push_back(x_raw);
                if (e_raw != m_filt_e && settled_to(hist_e, e_raw)) m_filt_e = e_raw;
                if (x_raw != m_filt_x && settled_to(hist_x, x_raw)) m_filt_x = x_raw;
`else
                le = e_raw; lx = x_raw;
`endif
                ev_e = le && !m_prev_e;
                ev_x = lx && !m_prev_x;
                m_prev_e = le; m_prev_x = lx;
            end
            if (ev_e && ev_x) begin
                opened = 1; open_in = 1;
            end else if (ev_e) begin
                if (m_count == MAX_SLOTS) rej = 1;
                else begin m_count++; opened = 1; open_in = 1; end
            end else if (ev_x) begin
                if (m_count == 0) rej = 1;
                else begin m_count--; opened = 1; open_in = 0; end
            end
            if (opened) begin
                m_gate_left = GATE_CYCLES; m_dir_in = open_in;
            end else if (m_gate_left > 0) begin
                m_gate_left--;
            end
        end
        o.state  = 4'(m_count);
        o.full   = (m_count == MAX_SLOTS);
        o.empty  = (m_count == 0);
        o.open   = (m_gate_left > 0);
        o.dir    = (m_gate_left > 0) && m_dir_in;
        o.reject = rej;
        exp_q.push_back(o);
    endtask

    task automatic tick(input bit r, input bit e, input bit x);
        reset            = r;
        bus.enter_sensor = e;
        bus.exit_sensor  = x;
        @(posedge clk);
        model_step(r, e, x);
        #1;
    endtask

    task automatic pulse(input bit e, input bit x, input int hi, input int lo);
        repeat (hi) tick(1'b0, e, x);
        repeat (lo) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a fresh output word.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                obs_t e_o;
                obs_t a_o;
                e_o = exp_q.pop_front();
                a_o = '{bus.fsm_state, bus.full, bus.empty, bus.gate_open, bus.gate_dir, bus.reject};
                check(phase, a_o, e_o);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit e_lvl;
        bit x_lvl;
        phase = "reset";
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        idle(2);

        phase = "enter3";
        repeat (3) pulse(1'b1, 1'b0, PW, PW);
        idle(12);

        phase = "fill";
        repeat (12) pulse(1'b1, 1'b0, PW, PW);
        phase = "full_reject";
        pulse(1'b1, 1'b0, PW, PW);
        idle(12);

        phase = "both_at_full";
        pulse(1'b1, 1'b1, PW, PW);
        idle(12);

        phase = "drain";
        repeat (15) pulse(1'b0, 1'b1, PW, PW);
        idle(12);
        phase = "empty_reject";
        pulse(1'b0, 1'b1, PW, PW);
        idle(12);

        phase = "enter_then_exit";
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        idle(2);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        idle(14);

        phase = "reset_mid_gate";
        repeat (7) pulse(1'b1, 1'b0, PW, PW);
        repeat (2) tick(1'b0, 1'b1, 1'b0);
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        repeat (8) tick(1'b0, 1'b1, 1'b0);
        idle(PW);
        pulse(1'b1, 1'b0, PW, 12);

        phase = "glitch";
        repeat (2) tick(1'b0, 1'b1, 1'b0);
        idle(12);

        phase = "random";
        tick(1'b1, 1'b0, 1'b0);
        e_lvl = 0;
        x_lvl = 0;
        for (int i = 0; i < 1600; i++) begin
            int pe;
            int px;
            pe = (i < 800) ? 3 : 9;
            px = (i < 800) ? 9 : 3;
            if ($urandom_range(pe - 1, 0) == 0) e_lvl = ~e_lvl;
            if ($urandom_range(px - 1, 0) == 0) x_lvl = ~x_lvl;
            tick(($urandom_range(399, 0) == 0), e_lvl, x_lvl);
        end
        idle(4);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
